// File: rtl/bally_pkg.sv
// Shared types and helpers for the Bally cart/BIOS loader.
package bally_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    MIR_RD,
    MIR_WAIT,
    MIR_WR,
    FILL,
    FIN
  } ldr_state_t;

  localparam logic [7:0] IDX_BIOS = 8'd0;
  localparam logic [7:0] IDX_CART = 8'd1;

  // Smallest power of two >= v (v == 0 yields 1); 65536 needs the 17th bit.
  function automatic logic [16:0] next_pow2(input logic [15:0] v);
    logic [16:0] p;
    p = 17'd1;
    for (int i = 0; i < 16; i++) begin
      if (p < {1'b0, v}) p = p << 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/bally_mirror_seq.sv
// Post-download sequencer: sizes the mirror block, then replicates it (or pads)
// across the whole RAM window one byte at a time.
module bally_mirror_seq
  import bally_pkg::*;
#(
  parameter int         ADDR_W  = 13,
  parameter int         MIN_BLK = 256,
  parameter logic [7:0] PAD     = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  ldr_state_t        state_q,
  input  logic [15:0]       img_size,
  input  logic [7:0]        ram_q,
  output ldr_state_t        seq_nxt,
  output logic              seq_ld,
  output logic              seq_we,
  output logic [ADDR_W-1:0] seq_addr,
  output logic [7:0]        seq_data
);

  localparam logic [16:0] WIN   = 17'd1 << ADDR_W;
  localparam logic [15:0] MIN_B = 16'(MIN_BLK);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] blk_q, blk_d;
  logic [16:0]       blk_req;
  logic [ADDR_W-1:0] mask;
  logic              last;

  always_comb begin
    blk_req  = next_pow2((img_size > MIN_B) ? img_size : MIN_B);
    mask     = blk_q - ADDR_W'(1);
    last     = &ptr_q;
    ptr_d    = ptr_q;
    blk_d    = blk_q;
    seq_nxt  = state_q;
    seq_ld   = 1'b0;
    seq_we   = 1'b0;
    seq_addr = ptr_q;
    seq_data = PAD;
    case (state_q)
      CALC: begin
        if (img_size == 16'd0) begin
          ptr_d   = '0;
          seq_nxt = FILL;
        end else if (blk_req >= WIN) begin
          seq_nxt = FIN;
        end else begin
          // Destination starts right after the first block; source wraps inside it.
          blk_d   = blk_req[ADDR_W-1:0];
          ptr_d   = blk_req[ADDR_W-1:0];
          seq_nxt = MIR_RD;
        end
      end
      MIR_RD: begin
        seq_ld   = 1'b1;
        seq_addr = ptr_q & mask;
        seq_nxt  = MIR_WAIT;
      end
      MIR_WAIT: seq_nxt = MIR_WR;
      MIR_WR: begin
        seq_ld   = 1'b1;
        seq_we   = 1'b1;
        seq_data = ram_q;
        ptr_d    = ptr_q + ADDR_W'(1);
        seq_nxt  = last ? FIN : MIR_RD;
      end
      FILL: begin
        seq_ld  = 1'b1;
        seq_we  = 1'b1;
        ptr_d   = ptr_q + ADDR_W'(1);
        seq_nxt = last ? FIN : FILL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      blk_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      blk_q <= blk_d;
    end
  end

endmodule

// File: rtl/bally_cart_loader.sv
// Turns the HPS download stream into cart/BIOS dpram writes, records the image
// size, then mirrors short images across the window while holding busy.
module bally_cart_loader
  import bally_pkg::*;
#(
  parameter int         ADDR_W  = 13,
  parameter int         MIN_BLK = 256,
  parameter logic [7:0] PAD     = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  input  logic [7:0]        ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we_cart,
  output logic              ram_we_bios,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       img_size
);

  ldr_state_t        state_q, state_d;
  logic              dl_q;
  logic              tgt_q, tgt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       img_q, img_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              we_cart_q, we_cart_d;
  logic              we_bios_q, we_bios_d;

  logic              rise, fall, in_win, wr_en;
  logic [25:0]       end_addr;
  logic [15:0]       wr_size;

  ldr_state_t        seq_nxt;
  logic              seq_ld, seq_we;
  logic [ADDR_W-1:0] seq_addr;
  logic [7:0]        seq_data;

  bally_mirror_seq #(
    .ADDR_W (ADDR_W),
    .MIN_BLK(MIN_BLK),
    .PAD    (PAD)
  ) u_seq (
    .clk_sys (clk_sys),
    .reset   (reset),
    .state_q (state_q),
    .img_size(img_q),
    .ram_q   (ram_q),
    .seq_nxt (seq_nxt),
    .seq_ld  (seq_ld),
    .seq_we  (seq_we),
    .seq_addr(seq_addr),
    .seq_data(seq_data)
  );

  always_comb begin
    rise     = ioctl_download & ~dl_q;
    fall     = ~ioctl_download & dl_q;
    in_win   = (ioctl_addr[24:ADDR_W] == '0);
    end_addr = {1'b0, ioctl_addr} + 26'd1;
    wr_size  = (end_addr > 26'h00_FFFF) ? 16'hFFFF : end_addr[15:0];

    state_d = state_q;
    tgt_d   = tgt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    img_d   = img_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise && (ioctl_index == IDX_BIOS || ioctl_index == IDX_CART)) begin
          tgt_d   = ioctl_index[0];
          img_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (ioctl_wr) begin
          if (in_win) begin
            addr_d = ioctl_addr[ADDR_W-1:0];
            data_d = ioctl_dout;
            wr_en  = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (wr_size > img_q) img_d = wr_size;
        end
        // A strobe coinciding with the falling edge is still taken above.
        if (fall) state_d = CALC;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = seq_nxt;
        if (seq_ld) addr_d = seq_addr;
        if (seq_we) begin
          data_d = seq_data;
          wr_en  = 1'b1;
        end
      end
    endcase

    we_cart_d = wr_en & tgt_q;
    we_bios_d = wr_en & ~tgt_q;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dl_q      <= 1'b0;
      tgt_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      img_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_cart_q <= 1'b0;
      we_bios_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dl_q      <= ioctl_download;
      tgt_q     <= tgt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      img_q     <= img_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_cart_q <= we_cart_d;
      we_bios_q <= we_bios_d;
    end
  end

  assign ram_addr    = addr_q;
  assign ram_data    = data_q;
  assign ram_we_cart = we_cart_q;
  assign ram_we_bios = we_bios_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign img_size    = img_q;

endmodule

// File: tb/tb_bally_cart_loader.sv
// Self-checking bench for bally_cart_loader: dpram models plus an image-level
// reference of what the window must hold after each download.
module tb_bally_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic [7:0]  ram_q = '0;
  logic [12:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we_cart, ram_we_bios, busy, done, overflow;
  logic [15:0] img_size;

  int checks = 0;
  int fails = 0;

  logic [7:0] cart_mem[8192];
  logic [7:0] bios_mem[8192];
  logic [7:0] exp_mem[8192];
  logic       mem_init_done = 1'b0;
  logic       tgt_sel = 1'b1;

  int cart_wr_cnt = 0, bios_wr_cnt = 0, done_cnt = 0, both_cnt = 0, stray_cnt = 0;

  bally_cart_loader dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_index   (ioctl_index),
    .ram_q         (ram_q),
    .ram_addr      (ram_addr),
    .ram_data      (ram_data),
    .ram_we_cart   (ram_we_cart),
    .ram_we_bios   (ram_we_bios),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .img_size      (img_size)
  );

  always #5 clk_sys = ~clk_sys;

  // Dual dprams with one-cycle registered read; contents start random.
  always @(posedge clk_sys) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 8192; i++) begin
        cart_mem[i] <= 8'($urandom);
        bios_mem[i] <= 8'($urandom);
      end
      mem_init_done <= 1'b1;
    end else begin
      if (ram_we_cart) cart_mem[ram_addr] <= ram_data;
      if (ram_we_bios) bios_mem[ram_addr] <= ram_data;
    end
    ram_q <= tgt_sel ? cart_mem[ram_addr] : bios_mem[ram_addr];
  end

  always begin
    @(posedge clk_sys);
    #1;
    if (ram_we_cart) cart_wr_cnt++;
    if (ram_we_bios) bios_wr_cnt++;
    if (ram_we_cart && ram_we_bios) both_cnt++;
    if ((ram_we_cart || ram_we_bios) && !busy) stray_cnt++;
    if (done) done_cnt++;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Starts a download, streams nbytes and records them in exp_mem; leaves
  // ioctl_download high unless fall_with_wr drops it with the last strobe.
  task automatic drive_file(input logic [7:0] idx, input int nbytes, input bit addr_data,
                            input bit fall_with_wr, input string tag);
    logic [7:0] d;
    @(negedge clk_sys);
    tgt_sel = idx[0];
    for (int i = 0; i < 8192; i++) exp_mem[i] = idx[0] ? cart_mem[i] : bios_mem[i];
    ioctl_index = idx;
    ioctl_download = 1'b1;
    wait_neg(2);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_in_load: got %b want 1", tag, busy);
    end
    for (int a = 0; a < nbytes; a++) begin
      d = addr_data ? 8'(a) : 8'($urandom);
      ioctl_addr = 25'(a);
      ioctl_dout = d;
      ioctl_wr = 1'b1;
      if (a < 8192) exp_mem[a] = d;
      if (a == nbytes - 1 && fall_with_wr) ioctl_download = 1'b0;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
    end
  endtask

  task automatic run_load(input logic [7:0] idx, input int nbytes, input bit addr_data,
                          input bit fall_with_wr, input string tag);
    int wc0, wb0, dn0, k, size, loads, mirr, blk, lat, bad, first_bad, dt, dother;
    logic t;
    logic [7:0] got;
    t = idx[0];
    wc0 = cart_wr_cnt;
    wb0 = bios_wr_cnt;
    dn0 = done_cnt;
    drive_file(idx, nbytes, addr_data, fall_with_wr, tag);
    if (fall_with_wr && nbytes > 0) k = 1;
    else begin
      ioctl_download = 1'b0;
      k = 0;
    end
    while (done !== 1'b1 && k < 40000) begin
      @(negedge clk_sys);
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s done_timeout: got %0d cycles without done", tag, k);
    end

    // Reference: image size, mirror block and resulting window contents.
    size  = (nbytes > 65535) ? 65535 : nbytes;
    loads = (nbytes < 8192) ? nbytes : 8192;
    if (size == 0) begin
      mirr = 8192;
      lat  = 8192 + 3;
      for (int i = 0; i < 8192; i++) exp_mem[i] = 8'hFF;
    end else begin
      blk = 256;
      while (blk < size && blk < 8192) blk = blk * 2;
      mirr = 8192 - blk;
      lat  = (blk == 8192) ? 3 : 3 * mirr + 3;
      for (int a = blk; a < 8192; a++) exp_mem[a] = exp_mem[a % blk];
    end

    checks++;
    if (k !== lat) begin
      fails++;
      $display("FAIL %s latency: got %0d want %0d", tag, k, lat);
    end
    checks++;
    if (img_size !== 16'(size)) begin
      fails++;
      $display("FAIL %s img_size: got %0d want %0d", tag, img_size, size);
    end
    checks++;
    if (overflow !== (nbytes > 8192)) begin
      fails++;
      $display("FAIL %s overflow: got %b want %b", tag, overflow, nbytes > 8192);
    end
    dt     = t ? cart_wr_cnt - wc0 : bios_wr_cnt - wb0;
    dother = t ? bios_wr_cnt - wb0 : cart_wr_cnt - wc0;
    checks++;
    if (dt !== loads + mirr) begin
      fails++;
      $display("FAIL %s target_writes: got %0d want %0d", tag, dt, loads + mirr);
    end
    checks++;
    if (dother !== 0) begin
      fails++;
      $display("FAIL %s other_writes: got %0d want 0", tag, dother);
    end
    @(negedge clk_sys);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - dn0 !== 1) begin
      fails++;
      $display("FAIL %s done_pulse: got done=%b busy=%b pulses=%0d want 0 0 1",
               tag, done, busy, done_cnt - dn0);
    end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 8192; i++) begin
      got = t ? cart_mem[i] : bios_mem[i];
      if (got !== exp_mem[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s ram_image: got %0d wrong bytes (first at %0d) want 0", tag, bad, first_bad);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    wait_neg(4);
    checks++;
    if ({ram_addr, ram_data, ram_we_cart, ram_we_bios, busy, done, overflow, img_size} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got addr=%0h data=%0h wc=%b wb=%b busy=%b done=%b ovf=%b size=%0d want all 0",
               ram_addr, ram_data, ram_we_cart, ram_we_bios, busy, done, overflow, img_size);
    end
    reset = 1'b0;
    wait_neg(2);
  endtask

  task automatic test_full_cart();
    run_load(8'd1, 8192, 1'b1, 1'b0, "full_cart");
  endtask

  task automatic test_cart_2048();
    run_load(8'd1, 2048, 1'b0, 1'b0, "cart_2048");
    checks++;
    if (cart_mem[6000] !== exp_mem[1904]) begin
      fails++;
      $display("FAIL cart_2048 ram6000: got %0h want %0h", cart_mem[6000], exp_mem[1904]);
    end
  endtask

  task automatic test_bios_300();
    run_load(8'd0, 300, 1'b0, 1'b0, "bios_300");
    checks++;
    if (bios_mem[700] !== exp_mem[188]) begin
      fails++;
      $display("FAIL bios_300 ram700: got %0h want %0h", bios_mem[700], exp_mem[188]);
    end
  endtask

  task automatic test_empty();
    run_load(8'd1, 0, 1'b0, 1'b0, "empty");
  endtask

  task automatic test_overflow();
    run_load(8'd1, 9000, 1'b1, 1'b0, "overflow_9000");
  endtask

  task automatic test_random_load();
    logic [7:0] idx;
    int n;
    idx = 8'($urandom_range(0, 1));
    n = $urandom_range(4097, 6000);
    run_load(idx, n, 1'b0, 1'b1, "random_fall_with_wr");
  endtask

  task automatic test_reset_mid_mirror();
    int dn0, wc0, wb0, k;
    bit busy_hi;
    dn0 = done_cnt;
    drive_file(8'd1, 512, 1'b0, 1'b0, "reset_mid");
    ioctl_download = 1'b0;
    k = 0;
    while (!(ram_we_cart === 1'b1 && k >= 3) && k < 100) begin
      @(negedge clk_sys);
      k++;
    end
    checks++;
    if (k >= 100) begin
      fails++;
      $display("FAIL reset_mid mirror_start: got no mirror write in %0d cycles", k);
    end
    wait_neg(2);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, ram_we_cart, ram_we_bios, done} !== 4'b0) begin
      fails++;
      $display("FAIL reset_mid abort: got busy=%b wc=%b wb=%b done=%b want 0",
               busy, ram_we_cart, ram_we_bios, done);
    end
    wait_neg(3);
    reset = 1'b0;
    wait_neg(10);
    checks++;
    if (done_cnt !== dn0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid no_done: got pulses=%0d busy=%b want 0 0", done_cnt - dn0, busy);
    end

    wc0 = cart_wr_cnt;
    wb0 = bios_wr_cnt;
    dn0 = done_cnt;
    busy_hi = 1'b0;
    ioctl_index = 8'd5;
    ioctl_download = 1'b1;
    for (int a = 0; a < 24; a++) begin
      ioctl_addr = 25'(a);
      ioctl_dout = 8'($urandom);
      ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      if (busy) busy_hi = 1'b1;
    end
    ioctl_download = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (busy) busy_hi = 1'b1;
    end
    checks++;
    if (busy_hi !== 1'b0) begin
      fails++;
      $display("FAIL bad_index busy: got %b want 0", busy_hi);
    end
    checks++;
    if (cart_wr_cnt - wc0 + bios_wr_cnt - wb0 !== 0 || done_cnt !== dn0) begin
      fails++;
      $display("FAIL bad_index writes: got writes=%0d pulses=%0d want 0 0",
               cart_wr_cnt - wc0 + bios_wr_cnt - wb0, done_cnt - dn0);
    end
  endtask

  task automatic test_global_rules();
    checks++;
    if (both_cnt !== 0) begin
      fails++;
      $display("FAIL both_we: got %0d cycles want 0", both_cnt);
    end
    checks++;
    if (stray_cnt !== 0) begin
      fails++;
      $display("FAIL write_while_idle: got %0d cycles want 0", stray_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_cart();
    test_cart_2048();
    test_bios_300();
    test_empty();
    test_overflow();
    test_reset_mid_mirror();
    test_random_load();
    test_global_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
